// File: rtl/uart_rx_core.sv
// ============================================================================
// uart_rx_core: 8N1 UART receiver, one-deep byte register with valid/ack.
// Option: UART_RX_MAJORITY_EN selects 2-of-3 majority sampling. Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module uart_rx_core #(
    parameter int CLK_HZ = 50000000,
    parameter int BAUD   = 9600,
    parameter int DIV    = CLK_HZ / BAUD,
    parameter int HALF   = DIV / 2
) (
    input  logic       clk_50m,
    input  logic       rst,
    input  logic       ser_rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ack,
    output logic       rx_frame_err,
    output logic       rx_overrun,
    output logic       rx_busy
);

    localparam int CW = $clog2(DIV);
    // Reload values are one less than the interval: the decision edge is the
    // one on which the counter already reads zero.
    localparam logic [CW-1:0] c_DIV_LOAD  = CW'(DIV - 1);
    localparam logic [CW-1:0] c_HALF_LOAD = CW'(HALF - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    state_t          r_state, w_state_next;
    logic [CW-1:0]   r_cnt, w_cnt_next;
    logic [2:0]      r_bit, w_bit_next;
    logic [7:0]      r_shift, w_shift_next;
    logic            r_sync1, r_rxs, r_rxs_d1;
    logic            w_sample, w_tick, w_byte_done, w_frame_err;

    always_ff @(posedge clk_50m) begin
        if (rst) begin
            r_sync1  <= 1'b1;
            r_rxs    <= 1'b1;
            r_rxs_d1 <= 1'b1;
        end else begin
            r_sync1  <= ser_rx;
            r_rxs    <= r_sync1;
            r_rxs_d1 <= r_rxs;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    logic r_rxs_d2;
    always_ff @(posedge clk_50m) begin
        if (rst) r_rxs_d2 <= 1'b1;
        else     r_rxs_d2 <= r_rxs_d1;
    end
    // Samples taken at counter values 2, 1 and 0; decision still at 0.
    assign w_sample = (r_rxs & r_rxs_d1) | (r_rxs & r_rxs_d2) | (r_rxs_d1 & r_rxs_d2);
`else
    assign w_sample = r_rxs;
`endif

    assign w_tick  = (r_cnt == '0);
    assign rx_busy = (r_state != S_IDLE);

    always_ff @(posedge clk_50m) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_bit   <= 3'd0;
            r_shift <= 8'h00;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_bit   <= w_bit_next;
            r_shift <= w_shift_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_bit_next   = r_bit;
        w_shift_next = r_shift;
        w_byte_done  = 1'b0;
        w_frame_err  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!r_rxs && r_rxs_d1) begin
                    w_cnt_next   = c_HALF_LOAD;
                    w_state_next = S_START;
                end
            end
            S_START: begin
                if (!w_tick) begin
                    w_cnt_next = r_cnt - 1'b1;
                end else if (!w_sample) begin
                    w_state_next = S_DATA;
                    w_cnt_next   = c_DIV_LOAD;
                    w_bit_next   = 3'd0;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_DATA: begin
                if (!w_tick) begin
                    w_cnt_next = r_cnt - 1'b1;
                end else begin
                    w_shift_next = {w_sample, r_shift[7:1]};
                    w_cnt_next   = c_DIV_LOAD;
                    if (r_bit == 3'd7) w_state_next = S_STOP;
                    else               w_bit_next   = r_bit + 3'd1;
                end
            end
            S_STOP: begin
                if (!w_tick) begin
                    w_cnt_next = r_cnt - 1'b1;
                end else if (w_sample) begin
                    w_byte_done  = 1'b1;
                    w_state_next = S_IDLE;
                end else begin
                    w_frame_err  = 1'b1;
                    w_state_next = S_BREAK;
                end
            end
            S_BREAK: begin
                if (r_rxs) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // A completing byte wins over ack; overrun is set only if nobody acked it.
    always_ff @(posedge clk_50m) begin
        if (rst) begin
            rx_data      <= 8'h00;
            rx_valid     <= 1'b0;
            rx_overrun   <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            rx_frame_err <= w_frame_err;
            if (w_byte_done) begin
                rx_data    <= r_shift;
                rx_valid   <= 1'b1;
                rx_overrun <= rx_valid & ~rx_ack;
            end else if (rx_ack && rx_valid) begin
                rx_valid   <= 1'b0;
                rx_overrun <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire
